cam_sequencer: RTL and testbench
================================

CAM_SEQUENCER -- requirements
Module: cam_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 1000: clk cycles cam_reset is held low at bring-up.
REQ-002 Parameter POLL_CYCLES, default 2000: clk cycles from the end of one read burst to the start of the next poll.
REQ-003 Parameter RETRY_MAX, default 3: consecutive NACKs tolerated per transaction before ERROR.
REQ-004 clk  in  1  sole clock (slow i2c-rate clock).
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins bring-up from IDLE or ERROR.
REQ-007 cam_reset  out  1  camera reset, active-low.
REQ-008 i2c_req  out  1  transaction request to i2c master.
REQ-009 i2c_rw  out  1  0 = write reg/data pair, 1 = read burst.
REQ-010 i2c_reg  out  8  register address (write).
REQ-011 i2c_wdata  out  8  write data.
REQ-012 i2c_len  out  5  read burst byte count (fixed 16).
REQ-013 i2c_busy  in  1  master accepted request and is active.
REQ-014 i2c_done  in  1  one-cycle pulse at transaction end.
REQ-015 i2c_nack  in  1  qualifies i2c_done; 1 = transaction failed.
REQ-016 rd_valid  in  1  one read byte present on rd_data.
REQ-017 rd_data  in  8  read byte.
REQ-018 x  out  10  blob-1 x coordinate.
REQ-019 y  out  10  blob-1 y coordinate.
REQ-020 xy_valid  out  1  one-cycle pulse when x/y update.
REQ-021 running  out  1  high in polling states; error  out  1  high in ERROR.

Function
REQ-022 States: IDLE, CAM_RST, RST_WAIT, INIT_REQ, INIT_WAIT, PTR_REQ, PTR_WAIT, RD_REQ, RD_DATA, POLL_WAIT, ERROR.
REQ-023 IDLE/ERROR + start -> CAM_RST; cam_reset low RST_CYCLES cycles, then RST_WAIT (cam_reset high, RST_CYCLES cycles) -> INIT_REQ.
REQ-024 Init table, 6 writes in order: (0x30,0x01) (0x30,0x08) (0x06,0x90) (0x08,0xC0) (0x1A,0x40) (0x33,0x33).
REQ-025 *_REQ states: drive i2c_req=1 with stable rw/reg/wdata/len until i2c_busy seen high, then drop i2c_req next cycle and enter matching *_WAIT.
REQ-026 *_WAIT on i2c_done & ~i2c_nack: INIT advances table index (after index 5 -> PTR_REQ); PTR -> RD_REQ.
REQ-027 *_WAIT on i2c_done & i2c_nack: retry counter +1, re-issue same transaction; counter > RETRY_MAX -> ERROR; counter clears on every success.
REQ-028 PTR_REQ writes (0x36, 0x00) ... wdata ignored by camera but driven 0x00.
REQ-029 RD_REQ issues read, i2c_len=16; RD_DATA counts rd_valid bytes 0..15.
REQ-030 Byte capture: b1,b2,b3 latched at indices 1,2,3; x = {b3[5:4], b1}, y = {b3[7:6], b2}.
REQ-031 On i2c_done & ~nack in RD_DATA with 16 bytes counted: x,y update and xy_valid pulses same cycle; -> POLL_WAIT.
REQ-032 b1=b2=b3=0xFF (no blob): x,y hold, xy_valid stays 0.
REQ-033 i2c_done before 16 bytes, or nack: treated as NACK per REQ-027; x,y unchanged.
REQ-034 POLL_WAIT counts POLL_CYCLES then -> PTR_REQ (no re-init).
REQ-035 start while not IDLE/ERROR: ignored.
REQ-036 rd_valid outside RD_DATA, i2c_done outside *_WAIT: ignored.

Reset
REQ-037 reset low at clk edge: state IDLE; cam_reset=1; i2c_req=0; i2c_rw=0; i2c_reg=0; i2c_wdata=0; i2c_len=16; x=0; y=0; xy_valid=0; running=0; error=0; all counters 0.
REQ-038 Reset mid-transaction drops i2c_req immediately; outstanding i2c_done after reset ignored.

Structure
REQ-039 Shared package holds state encoding, init table (addr/data pairs, length 6), camera register constants 0x36/0x33, burst length 16.
REQ-040 One sub-module natural: cam_wait_timer (loadable down-counter, done flag) shared by CAM_RST, RST_WAIT, POLL_WAIT.

Verification
REQ-041 start pulse, ideal master -> cam_reset low exactly RST_CYCLES, 6 writes in table order, then write 0x36 and 16-byte read.
REQ-042 Read bytes b1=0x34, b2=0x12, b3=0b10_01_0000 -> x=0x134, y=0x212, one xy_valid pulse.
REQ-043 Read b1..b3=0xFF -> no xy_valid, x/y hold prior values.
REQ-044 NACK on init write 3 twice then ack -> same (0x06,0x90) reissued twice, sequence continues; RETRY_MAX+1 NACKs -> error=1, i2c_req=0, later start restarts at CAM_RST.
REQ-045 reset low during RD_DATA -> next cycle all outputs at REQ-037 values; stray i2c_done ignored.
REQ-046 Two consecutive polls -> read starts spaced POLL_CYCLES after prior done; no init writes repeated.

Source files
------------

// File: rtl/cam_sequencer_pkg.sv
// Shared definitions for the camera sequencer: FSM encoding, camera register
// constants, burst geometry and the bring-up register table.
package cam_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CAM_RST,
        S_RST_WAIT,
        S_INIT_REQ,
        S_INIT_WAIT,
        S_PTR_REQ,
        S_PTR_WAIT,
        S_RD_REQ,
        S_RD_DATA,
        S_POLL_WAIT,
        S_ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } reg_pair_t;

    localparam int         INIT_LEN     = 6;
    localparam int         BURST_LEN    = 16;
    localparam logic [7:0] CAM_REG_PTR  = 8'h36;
    localparam logic [7:0] CAM_REG_MODE = 8'h33;
    localparam logic [7:0] NO_BLOB      = 8'hFF;

    // Bring-up writes, issued in index order.
    function automatic reg_pair_t init_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    init_entry = {8'h30, 8'h01};
            3'd1:    init_entry = {8'h30, 8'h08};
            3'd2:    init_entry = {8'h06, 8'h90};
            3'd3:    init_entry = {8'h08, 8'hC0};
            3'd4:    init_entry = {8'h1A, 8'h40};
            default: init_entry = {CAM_REG_MODE, CAM_REG_MODE};
        endcase
    endfunction

endpackage

// File: rtl/cam_sequencer_wait.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module cam_wait_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/cam_sequencer.sv
// Camera bring-up and blob-position polling sequencer driving an external
// i2c master: reset pulse, register init table, then periodic 16-byte reads.
module cam_sequencer
    import cam_sequencer_pkg::*;
#(
    parameter int RST_CYCLES  = 1000,
    parameter int POLL_CYCLES = 2000,
    parameter int RETRY_MAX   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       cam_reset,
    output logic       i2c_req,
    output logic       i2c_rw,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_wdata,
    output logic [4:0] i2c_len,
    input  logic       i2c_busy,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       xy_valid,
    output logic       running,
    output logic       error
);

    state_t      r_state, w_state;
    logic [2:0]  r_idx, w_idx;
    logic [7:0]  r_retry, w_retry;
    logic [4:0]  r_cnt;
    logic [7:0]  r_b1, r_b2, r_b3;
    logic [9:0]  r_x, r_y;
    logic        r_xy_valid;
    logic        w_load, w_tmr_done, w_rd_ok, w_give_up, w_no_blob;
    logic [31:0] w_load_val;
    reg_pair_t   w_entry;

    cam_wait_timer #(.W(32)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_tmr_done)
    );

    assign w_entry   = init_entry(r_idx);
    assign w_give_up = (r_retry >= 8'(RETRY_MAX));
    assign w_no_blob = (r_b1 == NO_BLOB) && (r_b2 == NO_BLOB) && (r_b3 == NO_BLOB);

    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_retry    = r_retry;
        w_load     = 1'b0;
        w_load_val = '0;
        w_rd_ok    = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: if (start) begin
                w_state    = S_CAM_RST;
                w_load     = 1'b1;
                w_load_val = 32'(RST_CYCLES - 1);
                w_idx      = '0;
                w_retry    = '0;
            end
            S_CAM_RST: if (w_tmr_done) begin
                w_state    = S_RST_WAIT;
                w_load     = 1'b1;
                w_load_val = 32'(RST_CYCLES - 1);
            end
            S_RST_WAIT:  if (w_tmr_done) w_state = S_INIT_REQ;
            S_INIT_REQ:  if (i2c_busy) w_state = S_INIT_WAIT;
            S_PTR_REQ:   if (i2c_busy) w_state = S_PTR_WAIT;
            S_RD_REQ:    if (i2c_busy) w_state = S_RD_DATA;
            S_INIT_WAIT: if (i2c_done) begin
                if (!i2c_nack) begin
                    w_retry = '0;
                    if (r_idx == 3'(INIT_LEN - 1)) begin
                        w_state = S_PTR_REQ;
                    end else begin
                        w_idx   = r_idx + 3'd1;
                        w_state = S_INIT_REQ;
                    end
                end else begin
                    w_retry = r_retry + 8'd1;
                    w_state = w_give_up ? S_ERROR : S_INIT_REQ;
                end
            end
            S_PTR_WAIT: if (i2c_done) begin
                if (!i2c_nack) begin
                    w_retry = '0;
                    w_state = S_RD_REQ;
                end else begin
                    w_retry = r_retry + 8'd1;
                    w_state = w_give_up ? S_ERROR : S_PTR_REQ;
                end
            end
            // A short burst counts as a failed read and is re-issued like a NACK.
            S_RD_DATA: if (i2c_done) begin
                if (!i2c_nack && (r_cnt == 5'(BURST_LEN))) begin
                    w_rd_ok    = 1'b1;
                    w_retry    = '0;
                    w_state    = S_POLL_WAIT;
                    w_load     = 1'b1;
                    w_load_val = 32'(POLL_CYCLES - 1);
                end else begin
                    w_retry = r_retry + 8'd1;
                    w_state = w_give_up ? S_ERROR : S_RD_REQ;
                end
            end
            S_POLL_WAIT: if (w_tmr_done) w_state = S_PTR_REQ;
            default:     w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_retry    <= '0;
            r_cnt      <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_b3       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_xy_valid <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_retry    <= w_retry;
            r_xy_valid <= 1'b0;
            if (r_state == S_RD_REQ) begin
                r_cnt <= '0;
            end else if ((r_state == S_RD_DATA) && rd_valid && (r_cnt < 5'(BURST_LEN))) begin
                if (r_cnt == 5'd1) r_b1 <= rd_data;
                if (r_cnt == 5'd2) r_b2 <= rd_data;
                if (r_cnt == 5'd3) r_b3 <= rd_data;
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_rd_ok && !w_no_blob) begin
                r_x        <= {r_b3[5:4], r_b1};
                r_y        <= {r_b3[7:6], r_b2};
                r_xy_valid <= 1'b1;
            end
        end
    end

    assign cam_reset = (r_state != S_CAM_RST);
    assign i2c_req   = (r_state == S_INIT_REQ) || (r_state == S_PTR_REQ) || (r_state == S_RD_REQ);
    assign i2c_rw    = (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
    assign i2c_len   = 5'(BURST_LEN);
    assign running   = (r_state == S_PTR_REQ) || (r_state == S_PTR_WAIT) || (r_state == S_RD_REQ) ||
                       (r_state == S_RD_DATA) || (r_state == S_POLL_WAIT);
    assign error     = (r_state == S_ERROR);
    assign x         = r_x;
    assign y         = r_y;
    assign xy_valid  = r_xy_valid;

    always_comb begin
        i2c_reg   = '0;
        i2c_wdata = '0;
        if ((r_state == S_INIT_REQ) || (r_state == S_INIT_WAIT)) begin
            i2c_reg   = w_entry.addr;
            i2c_wdata = w_entry.data;
        end else if ((r_state == S_PTR_REQ) || (r_state == S_PTR_WAIT)) begin
            i2c_reg   = CAM_REG_PTR;
        end
    end

endmodule

// File: tb/tb_cam_sequencer.sv
// Scoreboard bench for cam_sequencer: a scripted i2c master answers requests,
// a monitor compares every request and xy update against the expected queue.
module tb_cam_sequencer;

    localparam int RST_C  = 5;
    localparam int POLL_C = 7;
    localparam int RMAX   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       i2c_busy = 1'b0, i2c_done = 1'b0, i2c_nack = 1'b0, rd_valid = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       cam_reset, i2c_req, i2c_rw, xy_valid, running, error;
    logic [7:0] i2c_reg, i2c_wdata;
    logic [4:0] i2c_len;
    logic [9:0] x, y;

    cam_sequencer #(.RST_CYCLES(RST_C), .POLL_CYCLES(POLL_C), .RETRY_MAX(RMAX)) dut (
        .clk(clk), .reset(reset), .start(start), .cam_reset(cam_reset),
        .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_len(i2c_len), .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .rd_valid(rd_valid), .rd_data(rd_data), .x(x), .y(y), .xy_valid(xy_valid),
        .running(running), .error(error)
    );

    always #5 clk = ~clk;

    // kind: 0 = write, 1 = read, 2 = xy update; gap/hx/hy < 0 means not checked
    typedef struct { int kind; int a; int b; int gap; int hx; int hy; } exp_t;
    typedef struct { bit nack; int nbytes; int b1; int b2; int b3; } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    errors = 0, checks = 0, cyc = 0, last_done = 0;
    logic  prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic wr(input int a, input int d, input bit nack, input int gap = -1,
                      input int hx = -1, input int hy = -1);
        exp_q.push_back('{0, a, d, gap, hx, hy});
        plan_q.push_back('{nack, 0, 0, 0, 0});
    endtask

    task automatic rd(input bit nack, input int nb, input int b1, input int b2, input int b3);
        exp_q.push_back('{1, 0, 0, -1, -1, -1});
        plan_q.push_back('{nack, nb, b1, b2, b3});
    endtask

    task automatic exp_xy(input int ex, input int ey);
        exp_q.push_back('{2, ex, ey, -1, -1, -1});
    endtask

    task automatic init_writes(input bit nack3);
        wr(8'h30, 8'h01, 0);
        wr(8'h30, 8'h08, 0);
        if (nack3) begin
            wr(8'h06, 8'h90, 1);
            wr(8'h06, 8'h90, 1);
        end
        wr(8'h06, 8'h90, 0);
        wr(8'h08, 8'hC0, 0);
        wr(8'h1A, 8'h40, 0);
        wr(8'h33, 8'h33, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure_rst(input string nm);
        int n = 0;
        for (int k = 0; k < 10 && cam_reset; k++) @(negedge clk);
        while (!cam_reset && n < 10000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, RST_C);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cam_reset"}, cam_reset, 1);
        chk({tag, "_i2c_req"}, i2c_req, 0);
        chk({tag, "_i2c_rw"}, i2c_rw, 0);
        chk({tag, "_i2c_reg"}, i2c_reg, 0);
        chk({tag, "_i2c_wdata"}, i2c_wdata, 0);
        chk({tag, "_i2c_len"}, i2c_len, 16);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_xy_valid"}, xy_valid, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // Monitor: compares each new request and each xy pulse with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (i2c_req && !prev_req) begin
            $display("txn req  rw=%0d reg=0x%02h wdata=0x%02h len=%0d cyc=%0d",
                     i2c_rw, i2c_reg, i2c_wdata, i2c_len, cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got rw=%0d reg=0x%02h required no request", i2c_rw, i2c_reg);
            end else begin
                e = exp_q.pop_front();
                chk("req_kind", i2c_rw, e.kind);
                if (e.kind == 0) begin
                    chk("req_reg", i2c_reg, e.a);
                    chk("req_wdata", i2c_wdata, e.b);
                end else begin
                    chk("req_len", i2c_len, 16);
                end
                if (e.gap >= 0) chk("poll_gap", cyc - last_done, e.gap);
                if (e.hx >= 0) begin
                    chk("hold_x", x, e.hx);
                    chk("hold_y", y, e.hy);
                end
            end
        end
        if (xy_valid) begin
            $display("txn xy   x=0x%03h y=0x%03h cyc=%0d", x, y, cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_xy: got x=0x%03h y=0x%03h required no update", x, y);
            end else begin
                e = exp_q.pop_front();
                chk("xy_kind", 2, e.kind);
                chk("xy_x", x, e.a);
                chk("xy_y", y, e.b);
            end
        end
        prev_req = i2c_req;
    end

    // Scripted i2c master: one plan entry per accepted request.
    initial begin
        plan_t p;
        bit    rw;
        int    bv;
        forever begin
            @(negedge clk);
            if (i2c_req) begin
                if (plan_q.size() != 0) p = plan_q.pop_front();
                else p = '{0, 16, 255, 255, 255};
                rw = i2c_rw;
                i2c_busy = 1'b1;
                @(negedge clk);
                chk("req_drop", i2c_req, 0);
                if (rw) begin
                    for (int i = 0; i < p.nbytes; i++) begin
                        bv = (i == 1) ? p.b1 : (i == 2) ? p.b2 : (i == 3) ? p.b3 : 8'h50 + i;
                        rd_valid = 1'b1;
                        rd_data  = 8'(bv);
                        @(negedge clk);
                    end
                    rd_valid = 1'b0;
                    last_done = cyc;
                end else begin
                    @(negedge clk);
                end
                i2c_done = 1'b1;
                i2c_nack = p.nack;
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
                i2c_busy = 1'b0;
            end
        end
    end

    initial begin
        bit poked = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);

        // Bring-up with two NACKs on the third write, then four polls.
        init_writes(1);
        wr(8'h36, 8'h00, 0);
        rd(0, 16, 8'h34, 8'h12, 8'h90);
        exp_xy(10'h134, 10'h212);
        wr(8'h36, 8'h00, 0, POLL_C + 1, 10'h134, 10'h212);
        rd(0, 16, 8'hFF, 8'hFF, 8'hFF);
        wr(8'h36, 8'h00, 0, POLL_C + 1, 10'h134, 10'h212);
        rd(0, 10, 8'h01, 8'h02, 8'h00);
        rd(0, 16, 8'h01, 8'h02, 8'h00);
        exp_xy(10'h001, 10'h002);
        wr(8'h36, 8'h00, 1, POLL_C + 1, 10'h001, 10'h002);
        for (int i = 0; i < RMAX; i++) wr(8'h36, 8'h00, 1);

        pulse_start();
        measure_rst("cam_reset_low_1");
        for (int k = 0; k < 4000 && !(exp_q.size() == 0 && error); k++) begin
            if (running && !poked) begin
                poked = 1;
                pulse_start();
            end else begin
                @(negedge clk);
            end
        end
        chk("phase1_pending", exp_q.size(), 0);
        chk("err_flag", error, 1);
        chk("err_req", i2c_req, 0);
        chk("err_running", running, 0);

        // Restart from ERROR, then reset in the middle of the read burst.
        init_writes(0);
        wr(8'h36, 8'h00, 0);
        rd(0, 16, 8'h34, 8'h12, 8'h90);
        pulse_start();
        measure_rst("cam_reset_low_2");
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        chk("phase2_pending", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        chk("in_rd_data", i2c_rw, 1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_running", running, 0);
        chk("post_req", i2c_req, 0);
        chk("post_x", x, 0);
        chk("post_cam_reset", cam_reset, 1);
        chk("plan_left", plan_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
